param_mem_arbiter: RTL and testbench
====================================

Name: param_mem_arbiter

Overview:
- Shares the single-port parameters memory between N_RD read requesters (compute units) and one write requester (parameter loader).
- Guarantees read and write are never issued in the same cycle.
- Routes 1-cycle-latency read data back to the requester that issued the read.
- Sits between the CiM compute/load controllers and the params memory wrapper.

Parameters:
- N_RD, 4, number of read requesters (2..8).
- ADDR_W, 15, parameter word address width (flat address across both banks).
- DATA_W, 22, compute fixed-point word width (CompFx_t).
- FMT_W, 2, fixed-point format selector width.
- DEPTH, 31744, total valid words; addresses >= DEPTH are out of range.
- MAX_WR_STREAK, 8, consecutive write grants allowed while any read is pending.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rd_req  in  N_RD  per-requester read request.
- rd_addr  in  N_RD*ADDR_W  per-requester address, packed, requester i at [i*ADDR_W +: ADDR_W].
- rd_fmt  in  N_RD*FMT_W  per-requester format, packed the same way.
- rd_gnt  out  N_RD  one-hot (or zero) read grant, combinational, same cycle as request.
- rd_valid  out  N_RD  one-hot pulse, 1 cycle after grant.
- rd_data  out  DATA_W  read data, qualified by rd_valid.
- wr_req  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_fmt  in  FMT_W  write format.
- wr_gnt  out  1  write grant, combinational.
- mem_rd_en  out  1  to memory read interface.
- mem_rd_addr  out  ADDR_W  to memory read interface.
- mem_rd_fmt  out  FMT_W  to memory read interface.
- mem_rd_data  in  DATA_W  from memory; valid 1 cycle after mem_rd_en.
- mem_wr_en  out  1  to memory write interface.
- mem_wr_addr  out  ADDR_W  to memory write interface.
- mem_wr_data  out  DATA_W  to memory write interface.
- mem_wr_fmt  out  FMT_W  to memory write interface.
- mem_chip_en  out  1  memory chip enable.
- addr_err  out  1  sticky out-of-range flag.

Behaviour:
- Transfers:
  - A transfer occurs when req and gnt are both high in the same cycle.
  - Requesters hold req, addr and fmt stable until granted.
  - At most one of {wr_gnt, any rd_gnt} is high per cycle.
- Arbitration per cycle:
  - Write wins if wr_req and (no rd_req pending or wr_streak < MAX_WR_STREAK).
  - Otherwise the read requester is chosen round-robin, starting at rr_ptr.
- wr_streak counter:
  - Increments on each write grant while any rd_req is high, saturating at MAX_WR_STREAK.
  - Clears on any read grant, or in any cycle with no rd_req.
  - At saturation, the next cycle must grant a pending read.
- rr_ptr:
  - After granting reader k, rr_ptr = (k+1) mod N_RD.
  - Unchanged on write or idle cycles.
- Memory outputs are combinational from the grant:
  - mem_rd_en = read grant & in-range; mem_rd_addr/fmt = winner's addr/fmt.
  - mem_wr_en = wr_gnt & in-range; mem_wr_* = wr_*.
  - Idle address/data/fmt outputs = 0.
- mem_chip_en is held at 1 except during the reset cycle.
- Read return:
  - Registered rd_owner (one-hot) = rd_gnt. rd_valid = rd_owner next cycle.
  - rd_data = mem_rd_data when the registered request was in range, else 0.
  - rd_data = 0 when no rd_valid is high.
- Out-of-range access (addr >= DEPTH):
  - Still granted (no deadlock) and the memory enable is suppressed.
  - A read still returns rd_valid with data 0.
  - addr_err is set; it clears only on reset.
- Back-to-back:
  - The same requester may be granted on consecutive cycles.
  - A rd_valid pulse may coincide with a new grant.
- Reset values: rd_valid=0, rd_owner=0, rr_ptr=0, wr_streak=0, addr_err=0, mem_chip_en=0.
- Reset asserted mid-operation:
  - An in-flight read is dropped and no rd_valid is issued.
  - All combinational grants are forced to 0 while rst=1.

Test Plan:
- Reader 2 alone requests addr 0x0010 with memory word 0x1ABCD → rd_gnt=4'b0100 at cycle t; rd_valid=4'b0100 and rd_data=0x1ABCD at t+1.
- All 4 readers request continuously, rr_ptr=0 → grants in order 0,1,2,3,0 on consecutive cycles; each rd_valid follows its grant by 1 cycle.
- wr_req held high for 20 cycles with reader 1 also high, MAX_WR_STREAK=8 → 8 write grants, then 1 grant to reader 1, then writes resume; mem_rd_en and mem_wr_en never both 1.
- Write to addr 31744 → wr_gnt=1, mem_wr_en=0, addr_err=1 next cycle. Read from 31800 → rd_valid pulses with rd_data=0. addr_err stays 1 until rst.
- Reader 0 granted at cycle t, rst=1 at t+1 → rd_valid stays 0; after reset rr_ptr=0, addr_err=0, mem_chip_en returns to 1.
- Write 0x00123 to addr 0x7BFF, then reader 3 reads the same address → rd_data equals the written value (same fmt), one cycle after rd_gnt.

Source files
------------

// File: rtl/param_mem_arbiter.sv
// Arbiter sharing the single-port params memory between N_RD compute-unit readers
// and one parameter-loader writer; routes 1-cycle read data back to its issuer.

module param_mem_arbiter_lane #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 31744
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  assign in_range = ({1'b0, addr} < DEPTH_C);
endmodule

module param_mem_arbiter #(
  parameter int N_RD          = 4,
  parameter int ADDR_W        = 15,
  parameter int DATA_W        = 22,
  parameter int FMT_W         = 2,
  parameter int DEPTH         = 31744,
  parameter int MAX_WR_STREAK = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD-1:0]        rd_req,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  input  logic [N_RD*FMT_W-1:0]  rd_fmt,
  output logic [N_RD-1:0]        rd_gnt,
  output logic [N_RD-1:0]        rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  input  logic                   wr_req,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [FMT_W-1:0]       wr_fmt,
  output logic                   wr_gnt,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_rd_addr,
  output logic [FMT_W-1:0]       mem_rd_fmt,
  input  logic [DATA_W-1:0]      mem_rd_data,
  output logic                   mem_wr_en,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  output logic [DATA_W-1:0]      mem_wr_data,
  output logic [FMT_W-1:0]       mem_wr_fmt,
  output logic                   mem_chip_en,
  output logic                   addr_err
);
  localparam int PTR_W  = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int STRK_W = $clog2(MAX_WR_STREAK + 1);
  localparam logic [STRK_W-1:0] MAX_STRK = STRK_W'(MAX_WR_STREAK);
  localparam logic [PTR_W-1:0]  LAST_RD  = PTR_W'(N_RD - 1);

  logic [N_RD-1:0][ADDR_W-1:0] lane_addr;
  logic [N_RD-1:0][FMT_W-1:0]  lane_fmt;
  logic [N_RD-1:0]             lane_ok;
  logic                        wr_ok;

  assign lane_addr = rd_addr;
  assign lane_fmt  = rd_fmt;

  for (genvar i = 0; i < N_RD; i++) begin : g_lane
    param_mem_arbiter_lane #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lane (
      .addr     (lane_addr[i]),
      .in_range (lane_ok[i])
    );
  end

  param_mem_arbiter_lane #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_lane (
    .addr     (wr_addr),
    .in_range (wr_ok)
  );

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [STRK_W-1:0] wr_streak_q, wr_streak_d;
  logic [N_RD-1:0]   rd_owner_q, rd_owner_d;
  logic              rd_ok_q, rd_ok_d;
  logic              addr_err_q, addr_err_d;
  logic              chip_en_q, chip_en_d;

  logic              any_rd, wr_win, rd_hit;
  logic [PTR_W-1:0]  rd_sel;
  int                idx;

  always_comb begin
    any_rd = |rd_req;
    wr_win = wr_req && (!any_rd || (wr_streak_q < MAX_STRK));
    wr_gnt = !rst && wr_win;
    rd_gnt = '0;
    rd_sel = '0;
    rd_hit = 1'b0;
    idx    = 0;
    // Round-robin search begins at rr_ptr and wraps once around all readers.
    if (!rst && !wr_win) begin
      for (int k = 0; k < N_RD; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= N_RD) idx = idx - N_RD;
        if (!rd_hit && rd_req[idx]) begin
          rd_hit      = 1'b1;
          rd_sel      = idx[PTR_W-1:0];
          rd_gnt[idx] = 1'b1;
        end
      end
    end

    mem_rd_en   = rd_hit && lane_ok[rd_sel];
    mem_rd_addr = rd_hit ? lane_addr[rd_sel] : '0;
    mem_rd_fmt  = rd_hit ? lane_fmt[rd_sel]  : '0;
    mem_wr_en   = wr_gnt && wr_ok;
    mem_wr_addr = wr_gnt ? wr_addr : '0;
    mem_wr_data = wr_gnt ? wr_data : '0;
    mem_wr_fmt  = wr_gnt ? wr_fmt  : '0;

    rr_ptr_d = rr_ptr_q;
    if (rd_hit) rr_ptr_d = (rd_sel == LAST_RD) ? '0 : rd_sel + 1'b1;

    wr_streak_d = wr_streak_q;
    if (!any_rd || rd_hit)                     wr_streak_d = '0;
    else if (wr_gnt && wr_streak_q != MAX_STRK) wr_streak_d = wr_streak_q + 1'b1;

    rd_owner_d = rd_gnt;
    rd_ok_d    = mem_rd_en;
    addr_err_d = addr_err_q | (rd_hit && !lane_ok[rd_sel]) | (wr_gnt && !wr_ok);
    chip_en_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      wr_streak_q <= '0;
      rd_owner_q  <= '0;
      rd_ok_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      chip_en_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_streak_q <= wr_streak_d;
      rd_owner_q  <= rd_owner_d;
      rd_ok_q     <= rd_ok_d;
      addr_err_q  <= addr_err_d;
      chip_en_q   <= chip_en_d;
    end
  end

  // A read in flight when reset rises is dropped without waiting for the flop to clear.
  assign rd_valid    = rst ? '0 : rd_owner_q;
  assign rd_data     = (!rst && rd_ok_q) ? mem_rd_data : '0;
  assign addr_err    = addr_err_q;
  assign mem_chip_en = chip_en_q;

endmodule

// File: tb/tb_param_mem_arbiter.sv
// Directed bench for param_mem_arbiter: vector table plus hand sequences for
// write-streak fairness and reset during an in-flight read.

module tb_param_mem_arbiter;
  localparam int N_RD = 4, ADDR_W = 15, DATA_W = 22, FMT_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        rd_req;
  logic [59:0]       rd_addr;
  logic [7:0]        rd_fmt;
  logic [3:0]        rd_gnt, rd_valid;
  logic [21:0]       rd_data;
  logic              wr_req;
  logic [14:0]       wr_addr;
  logic [21:0]       wr_data;
  logic [1:0]        wr_fmt;
  logic              wr_gnt;
  logic              mem_rd_en, mem_wr_en, mem_chip_en, addr_err;
  logic [14:0]       mem_rd_addr, mem_wr_addr;
  logic [1:0]        mem_rd_fmt, mem_wr_fmt;
  logic [21:0]       mem_rd_data, mem_wr_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_mem_arbiter #(.N_RD(N_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FMT_W(FMT_W),
                      .DEPTH(31744), .MAX_WR_STREAK(8)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_fmt(rd_fmt),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_fmt(wr_fmt), .wr_gnt(wr_gnt),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_fmt(mem_rd_fmt),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_fmt(mem_wr_fmt), .mem_chip_en(mem_chip_en),
    .addr_err(addr_err)
  );

  // Memory model: unwritten word a reads as 0x100000|a, except word 0x10 = 0x1ABCD.
  // Without a read enable the output bus shows junk, so gating must come from the DUT.
  bit [21:0] mem_q [0:32767];
  bit        written [0:32767];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      if (written[mem_rd_addr])      mem_rd_data <= mem_q[mem_rd_addr];
      else if (mem_rd_addr == 15'h10) mem_rd_data <= 22'h1ABCD;
      else                            mem_rd_data <= 22'h100000 | {7'd0, mem_rd_addr};
    end else begin
      mem_rd_data <= 22'h2AAAA;
    end
    if (mem_wr_en) begin
      mem_q[mem_wr_addr]   <= mem_wr_data;
      written[mem_wr_addr] <= 1'b1;
    end
  end

  typedef struct {
    logic [3:0]  rd_req;
    logic [14:0] a3;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [21:0] wr_data;
    logic [3:0]  gnt;
    logic        wgnt;
    logic [3:0]  vld;
    logic [21:0] data;
    logic        mre;
    logic        mwe;
    logic        aerr;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd_addr(input logic [14:0] a3);
    rd_addr = {a3, 15'h10, 15'h21, 15'h20};
  endtask

  task automatic idle();
    rd_req = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  initial begin
    logic [14:0] ra;
    rst = 1'b1;
    idle();
    set_rd_addr(15'h23);
    rd_fmt = {2'd3, 2'd2, 2'd1, 2'd0};
    wr_fmt = 2'd3;

    // Reset state, with requests active to prove grants are held off.
    tick();
    rd_req = 4'b1111; wr_req = 1'b1;
    @(negedge clk);
    chk("reset_rd_gnt", rd_gnt, 0);
    chk("reset_wr_gnt", wr_gnt, 0);
    chk("reset_chip_en", mem_chip_en, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_addr_err", addr_err, 0);
    chk("reset_mem_rd_en", mem_rd_en, 0);
    tick();
    idle();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("chip_en_after_reset", mem_chip_en, 1);

    tbl[0]  = '{4'b1111, 15'h23,   1'b0, 15'h0,    22'h0,     4'b0001, 1'b0, 4'b0000, 22'h0,      1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 15'h23,   1'b0, 15'h0,    22'h0,     4'b0010, 1'b0, 4'b0001, 22'h100020, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4'b1111, 15'h23,   1'b0, 15'h0,    22'h0,     4'b0100, 1'b0, 4'b0010, 22'h100021, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{4'b1111, 15'h23,   1'b0, 15'h0,    22'h0,     4'b1000, 1'b0, 4'b0100, 22'h1ABCD,  1'b1, 1'b0, 1'b0};
    tbl[4]  = '{4'b1111, 15'h23,   1'b0, 15'h0,    22'h0,     4'b0001, 1'b0, 4'b1000, 22'h100023, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{4'b0100, 15'h23,   1'b0, 15'h0,    22'h0,     4'b0100, 1'b0, 4'b0001, 22'h100020, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{4'b0000, 15'h23,   1'b0, 15'h0,    22'h0,     4'b0000, 1'b0, 4'b0100, 22'h1ABCD,  1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b1000, 15'h23,   1'b0, 15'h0,    22'h0,     4'b1000, 1'b0, 4'b0000, 22'h0,      1'b1, 1'b0, 1'b0};
    tbl[8]  = '{4'b1000, 15'h23,   1'b0, 15'h0,    22'h0,     4'b1000, 1'b0, 4'b1000, 22'h100023, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'b0000, 15'h23,   1'b0, 15'h0,    22'h0,     4'b0000, 1'b0, 4'b1000, 22'h100023, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'b0000, 15'h23,   1'b1, 15'h7BFF, 22'h00123, 4'b0000, 1'b1, 4'b0000, 22'h0,      1'b0, 1'b1, 1'b0};
    tbl[11] = '{4'b1000, 15'h7BFF, 1'b0, 15'h0,    22'h0,     4'b1000, 1'b0, 4'b0000, 22'h0,      1'b1, 1'b0, 1'b0};
    tbl[12] = '{4'b0000, 15'h23,   1'b0, 15'h0,    22'h0,     4'b0000, 1'b0, 4'b1000, 22'h00123,  1'b0, 1'b0, 1'b0};
    tbl[13] = '{4'b0000, 15'h23,   1'b1, 15'h7C00, 22'h5,     4'b0000, 1'b1, 4'b0000, 22'h0,      1'b0, 1'b0, 1'b0};
    tbl[14] = '{4'b1000, 15'h7C38, 1'b0, 15'h0,    22'h0,     4'b1000, 1'b0, 4'b0000, 22'h0,      1'b0, 1'b0, 1'b1};
    tbl[15] = '{4'b0000, 15'h23,   1'b0, 15'h0,    22'h0,     4'b0000, 1'b0, 4'b1000, 22'h0,      1'b0, 1'b0, 1'b1};
    tbl[16] = '{4'b0000, 15'h23,   1'b0, 15'h0,    22'h0,     4'b0000, 1'b0, 4'b0000, 22'h0,      1'b0, 1'b0, 1'b1};

    for (int v = 0; v < 17; v++) begin
      tick();
      rd_req  = tbl[v].rd_req;
      set_rd_addr(tbl[v].a3);
      wr_req  = tbl[v].wr_req;
      wr_addr = tbl[v].wr_addr;
      wr_data = tbl[v].wr_data;
      @(negedge clk);
      chk($sformatf("v%0d_rd_gnt", v), rd_gnt, tbl[v].gnt);
      chk($sformatf("v%0d_wr_gnt", v), wr_gnt, tbl[v].wgnt);
      chk($sformatf("v%0d_rd_valid", v), rd_valid, tbl[v].vld);
      chk($sformatf("v%0d_rd_data", v), rd_data, tbl[v].data);
      chk($sformatf("v%0d_mem_rd_en", v), mem_rd_en, tbl[v].mre);
      chk($sformatf("v%0d_mem_wr_en", v), mem_wr_en, tbl[v].mwe);
      chk($sformatf("v%0d_addr_err", v), addr_err, tbl[v].aerr);
      ra = 15'h0;
      case (tbl[v].gnt)
        4'b0001: ra = 15'h20;
        4'b0010: ra = 15'h21;
        4'b0100: ra = 15'h10;
        4'b1000: ra = tbl[v].a3;
        default: ra = 15'h0;
      endcase
      chk($sformatf("v%0d_mem_rd_addr", v), mem_rd_addr, ra);
      chk($sformatf("v%0d_mem_wr_addr", v), mem_wr_addr, tbl[v].wgnt ? tbl[v].wr_addr : 15'h0);
      if (tbl[v].wgnt) chk($sformatf("v%0d_mem_wr_data", v), mem_wr_data, tbl[v].wr_data);
    end

    // Writer and reader 1 both asking for 20 cycles: 8 writes, 1 read, repeat.
    for (int c = 0; c < 20; c++) begin
      tick();
      rd_req  = 4'b0010;
      set_rd_addr(15'h23);
      wr_req  = 1'b1;
      wr_addr = 15'h100 + 15'(c);
      wr_data = 22'h3000 + 22'(c);
      @(negedge clk);
      chk($sformatf("streak%0d_wr_gnt", c), wr_gnt, (c == 8 || c == 17) ? 1'b0 : 1'b1);
      chk($sformatf("streak%0d_rd_gnt", c), rd_gnt, (c == 8 || c == 17) ? 4'b0010 : 4'b0000);
      chk($sformatf("streak%0d_exclusive", c), mem_rd_en & mem_wr_en, 0);
    end
    tick();
    idle();
    @(negedge clk);
    chk("streak_end_rd_valid", rd_valid, 4'b0000);

    // Reader 0 granted, then reset lands while its data is in flight.
    tick();
    rd_req = 4'b0001;
    @(negedge clk);
    chk("midrst_gnt", rd_gnt, 4'b0001);
    tick();
    rd_req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rd_valid", rd_valid, 4'b0000);
    chk("midrst_rd_data", rd_data, 0);
    tick();
    @(negedge clk);
    chk("midrst_rd_valid2", rd_valid, 4'b0000);
    chk("midrst_chip_en", mem_chip_en, 0);
    chk("midrst_addr_err", addr_err, 0);
    tick();
    rst = 1'b0;
    rd_req = 4'b1111;
    @(negedge clk);
    chk("postrst_rr_ptr0", rd_gnt, 4'b0001);
    tick();
    @(negedge clk);
    chk("postrst_chip_en", mem_chip_en, 1);
    chk("postrst_rd_valid", rd_valid, 4'b0001);
    chk("postrst_rd_data", rd_data, 22'h100020);
    chk("postrst_next_gnt", rd_gnt, 4'b0010);
    chk("postrst_addr_err", addr_err, 0);
    tick();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
